mac_dot_accum: RTL and testbench

//  Downstream stage of the MAC unit: consumes the stream of m_data results
//  (a*b+c) with a valid/ready handshake and sums LEN consecutive terms into
//  one dot-product result.
//  The result is held in an output register with its own valid/ready handshake
//  and a sticky overflow flag. Accumulation saturates; it never wraps.

---
 rtl/mac_dot_accum_pkg.sv | 14 +
 rtl/mac_sat_add.sv | 17 +
 rtl/mac_dot_accum.sv | 104 ++++++++++
 tb/tb_mac_dot_accum.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mac_dot_accum_pkg.sv
// Shared definitions for the MAC dot-product accumulator: FSM encoding and
// default widths shared with the MAC and its bench.
package mac_dot_accum_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    localparam int DEF_DW  = 8;
    localparam int DEF_AW  = 20;
    localparam int DEF_LEN = 4;

endpackage

// File: rtl/mac_sat_add.sv
// Unsigned saturating adder: clamps to all-ones when the carry out is set.
module mac_sat_add #(
    parameter int AW = 20
) (
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    output logic [AW-1:0] sum,
    output logic          sat
);

    logic [AW:0] raw;

    assign raw = {1'b0, a} + {1'b0, b};
    assign sat = raw[AW];
    assign sum = raw[AW] ? {AW{1'b1}} : raw[AW-1:0];

endmodule

// File: rtl/mac_dot_accum.sv
// Sums LEN consecutive MAC terms into one saturated dot-product result, held
// in an output register behind a valid/ready handshake.
module mac_dot_accum
    import mac_dot_accum_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int AW  = DEF_AW,
    parameter int LEN = DEF_LEN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] m_data,
    output logic          acc_valid,
    input  logic          acc_ready,
    output logic [AW-1:0] acc_data,
    output logic          acc_ovf
);

    localparam int CW = $clog2(LEN) + 1;

    state_e        state, state_nx;
    logic [CW-1:0] cnt;
    logic [AW-1:0] sum;
    logic          ovf;

    logic          beat, take, last, emit, step;
    logic [CW-1:0] cnt_inc;
    logic [AW-1:0] add_a, add_sum;
    logic          add_sat;

    assign in_ready = !acc_valid || acc_ready;
    assign beat     = in_valid && in_ready;
    assign take     = acc_valid && acc_ready;
    assign cnt_inc  = cnt + 1'b1;
    assign last     = (cnt_inc == CW'(LEN));

    // IDLE always starts from zero, so the first beat is a plain load.
    assign add_a = (state == ST_ACCUM) ? sum : '0;

    mac_sat_add #(.AW(AW)) u_add (
        .a   (add_a),
        .b   (AW'(m_data)),
        .sum (add_sum),
        .sat (add_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clr)
            state_nx = ST_IDLE;
        else if (beat)
            state_nx = last ? ST_IDLE : ST_ACCUM;
    end

    // A beat coinciding with clr is consumed but contributes nothing.
    always_comb begin
        emit = 1'b0;
        step = 1'b0;
        if (!clr && beat) begin
            emit = last;
            step = !last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sum <= '0;
            ovf <= 1'b0;
        end else if (clr || emit) begin
            cnt <= '0;
            sum <= '0;
            ovf <= 1'b0;
        end else if (step) begin
            cnt <= cnt_inc;
            sum <= add_sum;
            ovf <= ovf || add_sat;
        end
    end

    // Held result is independent of clr; only reset or a take releases it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_valid <= 1'b0;
            acc_data  <= '0;
            acc_ovf   <= 1'b0;
        end else if (emit) begin
            acc_valid <= 1'b1;
            acc_data  <= add_sum;
            acc_ovf   <= ovf || add_sat;
        end else if (take) begin
            acc_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_dot_accum.sv
// Bench for mac_dot_accum: two widths (AW=20 and AW=9) share one stimulus
// stream and are compared against a term-queue reference model.
module tb_mac_dot_accum;

    localparam int  LEN   = 4;
    localparam int  MAX20 = (1 << 20) - 1;
    localparam int  MAX9  = (1 << 9) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        acc_ready = 1'b0;
    logic [7:0]  m_data = '0;

    logic        rdy20, vld20, ovf20;
    logic [19:0] d20;
    logic        rdy9, vld9, ovf9;
    logic [8:0]  d9;

    int checks = 0;
    int errors = 0;

    int     q[$];
    bit     m_valid;
    int     m_d20, m_d9;
    bit     m_o20, m_o9;

    always #5 clk = ~clk;

    mac_dot_accum #(.DW(8), .AW(20), .LEN(LEN)) dut20 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy20),
        .m_data(m_data), .acc_valid(vld20), .acc_ready(acc_ready),
        .acc_data(d20), .acc_ovf(ovf20)
    );

    mac_dot_accum #(.DW(8), .AW(9), .LEN(LEN)) dut9 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy9),
        .m_data(m_data), .acc_valid(vld9), .acc_ready(acc_ready),
        .acc_data(d9), .acc_ovf(ovf9)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 0;
        m_d20 = 0; m_d9 = 0; m_o20 = 0; m_o9 = 0;
    endtask

    // Result is the plain sum clamped to the width's max; overflow iff clamped.
    task automatic model_emit();
        longint total = 0;
        foreach (q[i]) total += q[i];
        m_d20 = (total > MAX20) ? MAX20 : int'(total);
        m_o20 = (total > MAX20);
        m_d9  = (total > MAX9) ? MAX9 : int'(total);
        m_o9  = (total > MAX9);
        m_valid = 1;
        q.delete();
    endtask

    task automatic check_outputs();
        chk("acc_valid20", {31'b0, vld20}, {31'b0, m_valid});
        chk("acc_data20",  {12'b0, d20},   m_d20);
        chk("acc_ovf20",   {31'b0, ovf20}, {31'b0, m_o20});
        chk("acc_valid9",  {31'b0, vld9},  {31'b0, m_valid});
        chk("acc_data9",   {23'b0, d9},    m_d9);
        chk("acc_ovf9",    {31'b0, ovf9},  {31'b0, m_o9});
    endtask

    // One clock: drive at the falling edge, check ready, model the rising
    // edge, check registered outputs at the next falling edge.
    task automatic cyc(input bit v, input int d, input bit r, input bit c);
        bit exp_rdy, beat, take;
        in_valid = v; m_data = 8'(d); acc_ready = r; clr = c;
        #1;
        exp_rdy = !m_valid || r;
        chk("in_ready20", {31'b0, rdy20}, {31'b0, exp_rdy});
        chk("in_ready9",  {31'b0, rdy9},  {31'b0, exp_rdy});
        beat = v && exp_rdy;
        take = m_valid && r;
        @(posedge clk);
        if (take) m_valid = 0;
        if (c) q.delete();
        else if (beat) begin
            q.push_back(d);
            if (q.size() == LEN) model_emit();
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic reset_mid();
        in_valid = 0; clr = 0;
        #2 rst = 1'b1;
        #1;
        chk("rst_valid20", {31'b0, vld20}, 32'd0);
        chk("rst_data20",  {12'b0, d20},   32'd0);
        chk("rst_ovf20",   {31'b0, ovf20}, 32'd0);
        chk("rst_valid9",  {31'b0, vld9},  32'd0);
        chk("rst_data9",   {23'b0, d9},    32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit v; int d; bit r; bit c;
        bit ev; int e20; bit eo20; int e9; bit eo9;
    } vec_t;

    vec_t tbl[$];

    initial begin
        model_reset();
        tbl = '{
            '{1, 7,   1, 0, 0, 0,    0, 0,   0},
            '{1, 14,  1, 0, 0, 0,    0, 0,   0},
            '{1, 15,  1, 0, 0, 0,    0, 0,   0},
            '{1, 14,  1, 0, 1, 50,   0, 50,  0},
            '{1, 11,  1, 0, 0, 50,   0, 50,  0},
            '{1, 9,   1, 0, 0, 50,   0, 50,  0},
            '{1, 20,  1, 0, 0, 50,   0, 50,  0},
            '{1, 7,   1, 0, 1, 47,   0, 47,  0},
            '{0, 0,   1, 0, 0, 47,   0, 47,  0},
            '{1, 255, 1, 0, 0, 47,   0, 47,  0},
            '{1, 255, 1, 0, 0, 47,   0, 47,  0},
            '{1, 255, 1, 0, 0, 47,   0, 47,  0},
            '{1, 255, 1, 0, 1, 1020, 0, 511, 1},
            '{1, 1,   1, 0, 0, 1020, 0, 511, 1},
            '{1, 1,   1, 0, 0, 1020, 0, 511, 1},
            '{1, 1,   1, 0, 0, 1020, 0, 511, 1},
            '{1, 1,   1, 0, 1, 4,    0, 4,   0},
            '{0, 0,   1, 0, 0, 4,    0, 4,   0}
        };

        repeat (2) @(negedge clk);
        chk("reset_valid", {31'b0, vld20}, 32'd0);
        chk("reset_data",  {12'b0, d20},   32'd0);
        chk("reset_ovf",   {31'b0, ovf20}, 32'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].c);
            chk($sformatf("tbl%0d_valid", i), {31'b0, vld20}, {31'b0, tbl[i].ev});
            chk($sformatf("tbl%0d_d20", i),   {12'b0, d20},   tbl[i].e20);
            chk($sformatf("tbl%0d_o20", i),   {31'b0, ovf20}, {31'b0, tbl[i].eo20});
            chk($sformatf("tbl%0d_d9", i),    {23'b0, d9},    tbl[i].e9);
            chk($sformatf("tbl%0d_o9", i),    {31'b0, ovf9},  {31'b0, tbl[i].eo9});
        end

        // Backpressure: held 50 blocks input until the consumer takes it.
        cyc(1, 7, 1, 0); cyc(1, 14, 1, 0); cyc(1, 15, 1, 0); cyc(1, 14, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 5, 0, 0);
            chk("bp_in_ready", {31'b0, rdy20}, 32'd0);
            chk("bp_hold",     {12'b0, d20},   32'd50);
        end
        cyc(1, 1, 1, 0); cyc(1, 2, 1, 0); cyc(1, 3, 1, 0); cyc(1, 4, 1, 0);
        chk("bp_next_valid", {31'b0, vld20}, 32'd1);
        chk("bp_next_sum",   {12'b0, d20},   32'd10);
        cyc(0, 0, 1, 0);

        // clr drops a partial sum and the beat presented with it.
        cyc(1, 7, 1, 0); cyc(1, 14, 1, 0); cyc(1, 99, 1, 1);
        cyc(1, 2, 1, 0); cyc(1, 2, 1, 0); cyc(1, 2, 1, 0); cyc(1, 2, 1, 0);
        chk("clr_sum", {12'b0, d20}, 32'd8);
        cyc(0, 0, 1, 0);
        cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 1);
        chk("clr_held_valid", {31'b0, vld20}, 32'd1);
        chk("clr_held_data",  {12'b0, d20},   32'd4);
        cyc(0, 0, 1, 0);

        // Reset mid-accumulation, then while a result is held.
        cyc(1, 50, 1, 0); cyc(1, 60, 1, 0); cyc(1, 70, 1, 0);
        reset_mid();
        cyc(1, 3, 1, 0); cyc(1, 4, 1, 0); cyc(1, 5, 1, 0); cyc(1, 6, 1, 0);
        chk("post_rst_sum", {12'b0, d20}, 32'd18);
        cyc(1, 9, 0, 0); cyc(1, 9, 0, 0); cyc(1, 9, 0, 0); cyc(1, 9, 0, 0);
        reset_mid();
        cyc(0, 0, 1, 0);

        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 255),
                $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
